// File: rtl/pcie_bram_fifo_ctrl_pkg.sv
// Shared constants and helpers for the BRAM-backed 72-bit PCIe FIFO controller.
package pcie_bram_pkg;
  localparam int ADDR_W   = 11;
  localparam int DATA_W   = 72;
  localparam int RD_LAT   = 2;
  localparam int PF_DEPTH = 4;
  localparam int BRAM_AW  = 13;
  localparam int PF_AW    = $clog2(PF_DEPTH);
  localparam int PF_CNT_W = $clog2(PF_DEPTH + 1);
  localparam int CNT_W    = ADDR_W + 2;

  localparam logic [PF_CNT_W-1:0] PF_FULL = PF_CNT_W'(PF_DEPTH);

  // Number of reads still travelling through the BRAM output pipeline.
  function automatic logic [PF_CNT_W-1:0] tag_count(input logic [RD_LAT-1:0] tags);
    logic [PF_CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      n = n + PF_CNT_W'(tags[i]);
    end
    return n;
  endfunction
endpackage

// File: rtl/pcie_bram_fifo_ctrl_if.sv
// Stream, flush and BRAM-port bundle for the PCIe BRAM FIFO controller.
interface pcie_bram_fifo_ctrl_if;
  import pcie_bram_pkg::*;

  logic                flush;
  logic                s_valid;
  logic                s_ready;
  logic [DATA_W-1:0]   s_data;
  logic                m_valid;
  logic                m_ready;
  logic [DATA_W-1:0]   m_data;
  logic                bram_wen;
  logic [BRAM_AW-1:0]  bram_waddr;
  logic [DATA_W-1:0]   bram_wdata;
  logic                bram_ren;
  logic                bram_rce;
  logic [BRAM_AW-1:0]  bram_raddr;
  logic [DATA_W-1:0]   bram_rdata;
  logic [CNT_W-1:0]    count;

  modport slave (
    input  flush, s_valid, s_data, m_ready, bram_rdata,
    output s_ready, m_valid, m_data, bram_wen, bram_waddr, bram_wdata,
           bram_ren, bram_rce, bram_raddr, count
  );

  modport master (
    output flush, s_valid, s_data, m_ready, bram_rdata,
    input  s_ready, m_valid, m_data, bram_wen, bram_waddr, bram_wdata,
           bram_ren, bram_rce, bram_raddr, count
  );
endinterface

// File: rtl/pcie_bram_fifo_ctrl_prefetch.sv
// Small flop-based FIFO that absorbs words returning from the BRAM read pipeline.
module pcie_bram_prefetch
  import pcie_bram_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                push,
  input  logic [DATA_W-1:0]   push_data,
  input  logic                pop,
  output logic [DATA_W-1:0]   head,
  output logic [PF_CNT_W-1:0] cnt
);
  logic [DATA_W-1:0]   mem_r [PF_DEPTH];
  logic [PF_AW-1:0]    wr_ptr_r;
  logic [PF_AW-1:0]    rd_ptr_r;
  logic [PF_CNT_W-1:0] cnt_r;

  // Storage and pointers; the caller's credit scheme keeps push off a full buffer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= '0;
    end else if (clr) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= '0;
    end else begin
      if (push) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + PF_AW'(1);
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + PF_AW'(1);
      end
      cnt_r <= cnt_r + PF_CNT_W'(push) - PF_CNT_W'(pop);
    end
  end

  assign head = mem_r[rd_ptr_r];
  assign cnt  = cnt_r;
endmodule

// File: rtl/pcie_bram_fifo_ctrl.sv
// FIFO controller over a 2048x72 BRAM with a 2-cycle read pipeline and a prefetch buffer.
module pcie_bram_fifo_ctrl
  import pcie_bram_pkg::*;
(
  input  logic                  user_clk,
  input  logic                  rst_n,
  pcie_bram_fifo_ctrl_if.slave  bus
);
  localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

  logic [ADDR_W:0]     wptr_r;
  logic [ADDR_W:0]     rptr_r;
  logic [RD_LAT-1:0]   tag_r;
  logic [CNT_W-1:0]    count_r;
  logic                ready_en_r;

  logic [ADDR_W:0]     bram_cnt_s;
  logic [PF_CNT_W-1:0] inflight_s;
  logic [PF_CNT_W-1:0] pf_cnt_s;
  logic [DATA_W-1:0]   pf_head_s;
  logic                ready_s;
  logic                accept_s;
  logic                ren_s;
  logic                pop_s;

  // Handshake and read-issue decisions, all from registered state.
  always_comb begin
    bram_cnt_s = wptr_r - rptr_r;
    inflight_s = tag_count(tag_r);
    ready_s    = ready_en_r & (bram_cnt_s != FULL_CNT);
    accept_s   = rst_n & bus.s_valid & ready_s & !bus.flush;
    ren_s      = rst_n & !bus.flush & (bram_cnt_s != '0) &
                 ((inflight_s + pf_cnt_s) < PF_FULL);
    pop_s      = bus.m_ready & (pf_cnt_s != '0);
  end

  // Pointers, read-return tags and occupancy; flush clears everything but keeps s_ready up.
  always_ff @(posedge user_clk) begin
    if (!rst_n) begin
      wptr_r     <= '0;
      rptr_r     <= '0;
      tag_r      <= '0;
      count_r    <= '0;
      ready_en_r <= 1'b0;
    end else if (bus.flush) begin
      wptr_r     <= '0;
      rptr_r     <= '0;
      tag_r      <= '0;
      count_r    <= '0;
      ready_en_r <= 1'b1;
    end else begin
      if (accept_s) begin
        wptr_r <= wptr_r + (ADDR_W+1)'(1);
      end
      if (ren_s) begin
        rptr_r <= rptr_r + (ADDR_W+1)'(1);
      end
      tag_r      <= {tag_r[RD_LAT-2:0], ren_s};
      count_r    <= count_r + CNT_W'(accept_s) - CNT_W'(pop_s);
      ready_en_r <= 1'b1;
    end
  end

  pcie_bram_prefetch u_pf (
    .clk       (user_clk),
    .rst_n     (rst_n),
    .clr       (bus.flush),
    .push      (tag_r[RD_LAT-1]),
    .push_data (bus.bram_rdata),
    .pop       (pop_s),
    .head      (pf_head_s),
    .cnt       (pf_cnt_s)
  );

  assign bus.s_ready    = ready_s;
  assign bus.bram_wen   = accept_s;
  assign bus.bram_waddr = {{(BRAM_AW-ADDR_W){1'b0}}, wptr_r[ADDR_W-1:0]};
  assign bus.bram_wdata = bus.s_data;
  assign bus.bram_ren   = ren_s;
  assign bus.bram_rce   = 1'b1;
  assign bus.bram_raddr = {{(BRAM_AW-ADDR_W){1'b0}}, rptr_r[ADDR_W-1:0]};
  assign bus.m_valid    = (pf_cnt_s != '0);
  assign bus.m_data     = pf_head_s;
  assign bus.count      = count_r;
endmodule

// File: tb/tb_pcie_bram_fifo_ctrl.sv
// Directed bench for pcie_bram_fifo_ctrl: per-cycle vector table plus scoreboarded sequences.
module tb_pcie_bram_fifo_ctrl;
  import pcie_bram_pkg::*;

  logic user_clk = 1'b0;
  logic rst_n;
  pcie_bram_fifo_ctrl_if bus();

  pcie_bram_fifo_ctrl dut (
    .user_clk (user_clk),
    .rst_n    (rst_n),
    .bus      (bus)
  );

  always #5 user_clk = ~user_clk;

  // Behavioural BRAM: registered read plus output register gives two cycles of latency.
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rd_stage;
  always @(posedge user_clk) begin
    if (bus.bram_wen) mem[bus.bram_waddr[ADDR_W-1:0]] <= bus.bram_wdata;
    if (bus.bram_ren) rd_stage <= mem[bus.bram_raddr[ADDR_W-1:0]];
    if (bus.bram_rce) bus.bram_rdata <= rd_stage;
  end

  typedef struct {
    logic             s_valid;
    logic [7:0]       tag;
    logic             m_ready;
    logic             flush;
    logic             e_s_ready;
    logic             e_wen;
    logic             e_ren;
    logic             e_m_valid;
    logic [7:0]       e_tag;
    logic [CNT_W-1:0] e_count;
  } vec_t;

  vec_t              vt [15];
  logic [DATA_W-1:0] sb [$];
  int                tests = 0;
  int                fails = 0;
  int                n_acc = 0;
  logic [BRAM_AW-1:0] last_raddr = '0;
  logic              saw_wrap = 1'b0;
  logic              seen;

  function automatic logic [DATA_W-1:0] dat(input logic [7:0] t);
    return {8'hA5, 56'h0, t};
  endfunction

  function automatic vec_t mk(input logic sv, input logic [7:0] t, input logic mr, input logic fl,
                              input logic sr, input logic wen, input logic ren, input logic mv,
                              input logic [7:0] et, input int cnt);
    vec_t v;
    v.s_valid = sv;  v.tag = t;      v.m_ready = mr;  v.flush = fl;
    v.e_s_ready = sr; v.e_wen = wen; v.e_ren = ren;   v.e_m_valid = mv;
    v.e_tag = et;    v.e_count = CNT_W'(cnt);
    return v;
  endfunction

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at the negedge: scoreboard bookkeeping, then advance to just past the next posedge.
  task automatic sample_advance();
    if (bus.bram_wen && bus.bram_ren)
      chk("port_collision", DATA_W'(bus.bram_raddr != bus.bram_waddr), 72'd1);
    if (bus.bram_ren) begin
      if (last_raddr == BRAM_AW'(2047) && bus.bram_raddr == '0) saw_wrap = 1'b1;
      last_raddr = bus.bram_raddr;
    end
    if (!rst_n || bus.flush) begin
      sb.delete();
    end else begin
      if (bus.m_valid && bus.m_ready) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL pop_order: popped %h with nothing expected", bus.m_data);
        end else begin
          chk("pop_data", bus.m_data, sb.pop_front());
        end
      end
      if (bus.s_valid && bus.s_ready) begin
        sb.push_back(bus.s_data);
        n_acc++;
      end
    end
    @(posedge user_clk);
    #1;
  endtask

  task automatic cycle();
    @(negedge user_clk);
    sample_advance();
  endtask

  task automatic chk_reset_outputs(input string p);
    chk({p, "_s_ready"}, DATA_W'(bus.s_ready), 72'd0);
    chk({p, "_m_valid"}, DATA_W'(bus.m_valid), 72'd0);
    chk({p, "_wen"},     DATA_W'(bus.bram_wen), 72'd0);
    chk({p, "_ren"},     DATA_W'(bus.bram_ren), 72'd0);
    chk({p, "_waddr"},   DATA_W'(bus.bram_waddr), 72'd0);
    chk({p, "_raddr"},   DATA_W'(bus.bram_raddr), 72'd0);
    chk({p, "_count"},   DATA_W'(bus.count), 72'd0);
  endtask

  task automatic wait_ready(input string p);
    for (int i = 0; i < 10 && !bus.s_ready; i++) cycle();
    chk({p, "_ready_timeout"}, DATA_W'(bus.s_ready), 72'd1);
  endtask

  task automatic drain(input string p);
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    for (int i = 0; i < 3000 && bus.count != '0; i++) cycle();
    chk({p, "_drain_count"}, DATA_W'(bus.count), 72'd0);
    chk({p, "_drain_sb_left"}, DATA_W'(sb.size()), 72'd0);
  endtask

  initial begin
    // sv tag mr fl | s_ready wen ren m_valid etag count
    vt[0]  = mk(1, 8'h01, 1, 0, 1, 1, 0, 0, 8'h00, 0);
    vt[1]  = mk(1, 8'h02, 1, 0, 1, 1, 1, 0, 8'h00, 1);
    vt[2]  = mk(1, 8'h03, 1, 0, 1, 1, 1, 0, 8'h00, 2);
    vt[3]  = mk(1, 8'h04, 1, 0, 1, 1, 1, 0, 8'h00, 3);
    vt[4]  = mk(1, 8'h05, 1, 0, 1, 1, 1, 1, 8'h01, 4);
    vt[5]  = mk(1, 8'h06, 1, 0, 1, 1, 1, 1, 8'h02, 4);
    vt[6]  = mk(1, 8'h07, 1, 0, 1, 1, 1, 1, 8'h03, 4);
    vt[7]  = mk(1, 8'h08, 1, 0, 1, 1, 1, 1, 8'h04, 4);
    vt[8]  = mk(0, 8'h00, 1, 0, 1, 0, 1, 1, 8'h05, 4);
    vt[9]  = mk(0, 8'h00, 1, 0, 1, 0, 0, 1, 8'h06, 3);
    vt[10] = mk(0, 8'h00, 1, 0, 1, 0, 0, 1, 8'h07, 2);
    vt[11] = mk(0, 8'h00, 1, 0, 1, 0, 0, 1, 8'h08, 1);
    vt[12] = mk(0, 8'h00, 1, 0, 1, 0, 0, 0, 8'h00, 0);
    vt[13] = mk(1, 8'h99, 1, 1, 1, 0, 0, 0, 8'h00, 0);
    vt[14] = mk(0, 8'h00, 1, 0, 1, 0, 0, 0, 8'h00, 0);

    rst_n = 1'b0;
    bus.flush = 1'b0; bus.s_valid = 1'b0; bus.s_data = '0; bus.m_ready = 1'b0;
    cycle(); cycle();
    @(negedge user_clk);
    chk_reset_outputs("reset");
    sample_advance();
    rst_n = 1'b1;
    cycle();
    wait_ready("reset_release");

    // Table: 8 words through an empty FIFO, then a flush with a dropped write.
    for (int i = 0; i < 15; i++) begin
      bus.s_valid = vt[i].s_valid;
      bus.s_data  = dat(vt[i].tag);
      bus.m_ready = vt[i].m_ready;
      bus.flush   = vt[i].flush;
      @(negedge user_clk);
      chk($sformatf("vec%0d_s_ready", i), DATA_W'(bus.s_ready), DATA_W'(vt[i].e_s_ready));
      chk($sformatf("vec%0d_wen", i),     DATA_W'(bus.bram_wen), DATA_W'(vt[i].e_wen));
      chk($sformatf("vec%0d_ren", i),     DATA_W'(bus.bram_ren), DATA_W'(vt[i].e_ren));
      chk($sformatf("vec%0d_m_valid", i), DATA_W'(bus.m_valid), DATA_W'(vt[i].e_m_valid));
      if (vt[i].e_m_valid)
        chk($sformatf("vec%0d_m_data", i), bus.m_data, dat(vt[i].e_tag));
      chk($sformatf("vec%0d_count", i),   DATA_W'(bus.count), DATA_W'(vt[i].e_count));
      sample_advance();
    end
    bus.flush = 1'b0;

    // Fill with the consumer stalled: 2048 in BRAM plus 4 prefetched.
    n_acc = 0;
    bus.m_ready = 1'b0;
    bus.s_valid = 1'b1;
    for (int k = 0; k < 2100; k++) begin
      bus.s_data = {8'hB0, 48'h0, 16'(k)};
      cycle();
    end
    chk("fill_accepted", DATA_W'(n_acc), 72'd2052);
    @(negedge user_clk);
    chk("full_s_ready", DATA_W'(bus.s_ready), 72'd0);
    chk("full_ren", DATA_W'(bus.bram_ren), 72'd0);
    chk("full_count", DATA_W'(bus.count), 72'd2052);
    chk("full_m_valid", DATA_W'(bus.m_valid), 72'd1);
    chk("full_head", bus.m_data, {8'hB0, 48'h0, 16'd0});
    // Pop while full: s_ready must still be low in this same cycle.
    bus.m_ready = 1'b1;
    #1;
    chk("full_pop_s_ready", DATA_W'(bus.s_ready), 72'd0);
    sample_advance();

    // Toggled consumer while writing; order must survive the read-address wrap.
    saw_wrap = 1'b0;
    for (int k = 0; k < 4500; k++) begin
      bus.m_ready = k[0];
      bus.s_data  = {8'hC0, 48'h0, 16'(k)};
      cycle();
    end
    chk("read_addr_wrapped", DATA_W'(saw_wrap), 72'd1);

    // Flush with two reads in flight.
    bus.s_valid = 1'b0; bus.flush = 1'b1;
    cycle();
    bus.flush = 1'b0; bus.m_ready = 1'b1;
    bus.s_valid = 1'b1; bus.s_data = {8'hD0, 64'd1}; cycle();
    bus.s_data = {8'hD0, 64'd2}; cycle();
    bus.s_valid = 1'b0; cycle();
    bus.flush = 1'b1; cycle();
    bus.flush = 1'b0;
    @(negedge user_clk);
    chk("flush_m_valid", DATA_W'(bus.m_valid), 72'd0);
    chk("flush_count", DATA_W'(bus.count), 72'd0);
    sample_advance();
    for (int i = 0; i < 6; i++) begin
      @(negedge user_clk);
      chk($sformatf("flush_squash%0d", i), DATA_W'(bus.m_valid), 72'd0);
      sample_advance();
    end
    bus.s_valid = 1'b1; bus.s_data = {8'hD0, 64'd3}; cycle();
    bus.s_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge user_clk);
      if (bus.m_valid) begin
        seen = 1'b1;
        chk("post_flush_first", bus.m_data, {8'hD0, 64'd3});
      end
      sample_advance();
    end
    chk("post_flush_seen", DATA_W'(seen), 72'd1);

    // One-cycle reset in the middle of a stream.
    bus.s_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      bus.s_data = {8'hE0, 64'(k)};
      cycle();
    end
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    @(negedge user_clk);
    chk_reset_outputs("midreset");
    sample_advance();
    wait_ready("midreset_release");
    for (int k = 0; k < 30; k++) begin
      bus.s_data = {8'hF0, 64'(k)};
      cycle();
    end
    drain("midreset");

    // Random 50% valid / 50% ready traffic.
    for (int k = 0; k < 3000; k++) begin
      bus.s_valid = 1'($urandom_range(0, 1));
      bus.m_ready = 1'($urandom_range(0, 1));
      bus.s_data  = {8'($urandom), $urandom, $urandom};
      cycle();
    end
    drain("random");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
